ram_burst_ctrl: RTL and testbench

//  Burst sequencer upstream of the 32x32 single-port RAM; sole driver of its ena/wena/addr/data_in.

---
 rtl/ram_burst_ctrl_pkg.sv | 15 +
 rtl/ram_burst_ctrl_rd_skid_fifo.sv | 44 ++++
 rtl/ram_burst_ctrl.sv | 150 +++++++++++++++
 tb/tb_ram_burst_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_burst_ctrl_pkg.sv
// Shared definitions for the RAM burst controller: FSM state encoding and default widths.
package ram_burst_ctrl_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LEN_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/ram_burst_ctrl_rd_skid_fifo.sv
// Two-entry FIFO that parks RAM read data while the consumer applies backpressure.
module ram_burst_ctrl_rd_skid_fifo #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) wr_ptr_q <= ~wr_ptr_q;
      if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst sequencer in front of the single-port RAM: turns one request into consecutive
// single-cycle RAM accesses, fed by a write stream and draining into a read stream.
module ram_burst_ctrl
  import ram_burst_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              ram_ena,
  output logic              ram_wena,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [LEN_W-1:0]  left_q, left_d;
  logic              inflight_q, inflight_d;
  logic              done_q, done_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic [2:0]        occ;
  logic              consume, space_ok;

  ram_burst_ctrl_rd_skid_fifo #(
    .DATA_W (DATA_W)
  ) u_rd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .data_i  (ram_data_out),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // An empty buffer lets the returning RAM word straight through, so a read beat
  // appears the cycle after its issue; otherwise the buffered head goes first.
  assign rd_valid  = !fifo_empty || inflight_q;
  assign rd_data   = (fifo_empty && inflight_q) ? ram_data_out : fifo_head;
  assign consume   = rd_valid && rd_ready;
  assign fifo_pop  = rd_ready && !fifo_empty;
  assign fifo_push = inflight_q && !(fifo_empty && rd_ready);

  // Occupancy counts the in-flight word as already buffered; issuing is safe when
  // at most one slot stays taken after this cycle's consumption.
  assign occ      = {1'b0, fifo_full, (!fifo_full && !fifo_empty)} + {2'b00, inflight_q};
  assign space_ok = (occ - {2'b00, consume}) < 3'd2;

  assign ram_data_in = wr_data;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    left_d      = left_q;
    last_addr_d = last_addr_q;
    inflight_d  = 1'b0;
    done_d      = 1'b0;
    req_ready   = 1'b0;
    wr_ready    = 1'b0;
    ram_ena     = 1'b0;
    ram_wena    = 1'b0;
    ram_addr    = last_addr_q;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = req_write ? ST_WRITE : ST_READ;
          cnt_d   = req_addr;
          left_d  = req_len;
        end
      end
      ST_WRITE: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          ram_ena     = 1'b1;
          ram_wena    = 1'b1;
          ram_addr    = cnt_q;
          last_addr_d = cnt_q;
          cnt_d       = cnt_q + ADDR_W'(1);
          if (left_q == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            left_d = left_q - LEN_W'(1);
          end
        end
      end
      ST_READ: begin
        if (space_ok) begin
          ram_ena     = 1'b1;
          ram_addr    = cnt_q;
          last_addr_d = cnt_q;
          inflight_d  = 1'b1;
          cnt_d       = cnt_q + ADDR_W'(1);
          if (left_q == '0) state_d = ST_DRAIN;
          else              left_d  = left_q - LEN_W'(1);
        end
      end
      ST_DRAIN: begin
        if (occ == {2'b00, consume}) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      left_q      <= '0;
      last_addr_q <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      left_q      <= left_d;
      last_addr_q <= last_addr_d;
      inflight_q  <= inflight_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Bench for ram_burst_ctrl with a behavioural 32x32 synchronous RAM on the ram_* side;
// read data is checked against a scoreboard queue filled when each read request is made.
module tb_ram_burst_ctrl;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready, req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              wr_valid, wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid, rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              busy, done;
  logic              ram_ena, ram_wena;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data_in, ram_data_out;

  logic [DATA_W-1:0] ram_mem [32];
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] exp_mem [32];
  logic [DATA_W-1:0] sb_q [$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ram_burst_ctrl #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_len      (req_len),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .busy         (busy),
    .done         (done),
    .ram_ena      (ram_ena),
    .ram_wena     (ram_wena),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  // Synchronous single-port RAM: read data appears the cycle after the access.
  always @(posedge clk) begin
    if (ram_ena) begin
      if (ram_wena) ram_mem[ram_addr] <= ram_data_in;
      else          ram_q <= ram_mem[ram_addr];
    end
  end
  assign ram_data_out = ram_q;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({req_ready, wr_ready, rd_valid, busy, done, ram_ena, ram_wena} !== 7'b1000000) begin
      errors++;
      $display("[TB] FAIL reset_flags got=%b exp=1000000",
               {req_ready, wr_ready, rd_valid, busy, done, ram_ena, ram_wena});
    end
    checks++;
    if (ram_addr !== 5'd0) begin
      errors++;
      $display("[TB] FAIL reset_addr got=%0d exp=0", ram_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_write(input logic [4:0] addr, input logic [4:0] len, input logic [31:0] base,
                          input bit gaps, input bit spam, input string name);
    logic [4:0] a;
    int beat;
    int cyc;
    int nbeats;
    a      = addr;
    beat   = 0;
    cyc    = 0;
    nbeats = int'(len) + 1;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_len = len;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_req_ready got=%b exp=1", name, req_ready);
    end
    @(negedge clk);
    req_valid = spam; req_write = 1'b0; req_addr = ~addr; req_len = 5'd2;
    while (beat < nbeats && cyc < 200) begin
      wr_valid = !(gaps && (cyc % 3 == 1));
      wr_data  = base * (beat + 1);
      #1;
      checks++;
      if (req_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL %s_busy got req_ready=%b busy=%b exp req_ready=0 busy=1", name, req_ready, busy);
      end
      if (wr_valid) begin
        checks++;
        if ({ram_ena, ram_wena, wr_ready} !== 3'b111 || ram_addr !== a || ram_data_in !== wr_data) begin
          errors++;
          $display("[TB] FAIL %s_beat%0d got ena/wena/rdy=%b addr=%0d data=%0d exp 111 addr=%0d data=%0d",
                   name, beat, {ram_ena, ram_wena, wr_ready}, ram_addr, ram_data_in, a, wr_data);
        end
        exp_mem[a] = wr_data;
        a++;
        beat++;
      end else begin
        checks++;
        if (ram_ena !== 1'b0) begin
          errors++;
          $display("[TB] FAIL %s_gap_ena got=%b exp=0", name, ram_ena);
        end
      end
      @(negedge clk);
      cyc++;
    end
    wr_valid  = 1'b0;
    req_valid = 1'b0;
    if (cyc >= 200) begin
      errors++;
      $display("[TB] FAIL %s_timeout got beats=%0d exp=%0d", name, beat, nbeats);
    end
    #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_done got done=%b busy=%b exp done=1 busy=0", name, done, busy);
    end
    @(negedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_done_pulse got=%b exp=0", name, done);
    end
  endtask

  // rdy_mode 0: always ready; 1: ready pattern 1,0,0,1. abort_after>0 stops after that many beats.
  task automatic do_read(input logic [4:0] addr, input logic [4:0] len, input int rdy_mode,
                         input int abort_after, input string name);
    logic [4:0]  a;
    logic [4:0]  idx;
    logic [31:0] exp;
    int issued;
    int got;
    int cyc;
    int nbeats;
    a      = addr;
    idx    = addr;
    issued = 0;
    got    = 0;
    cyc    = 0;
    nbeats = int'(len) + 1;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = addr; req_len = len;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_req_ready got=%b exp=1", name, req_ready);
    end
    for (int i = 0; i < nbeats; i++) begin
      sb_q.push_back(exp_mem[idx]);
      idx++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    while (got < nbeats && cyc < 300) begin
      rd_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      #1;
      if (ram_ena) begin
        checks++;
        if (ram_wena !== 1'b0 || ram_addr !== a) begin
          errors++;
          $display("[TB] FAIL %s_issue%0d got wena=%b addr=%0d exp wena=0 addr=%0d", name, issued, ram_wena, ram_addr, a);
        end
        a++;
        issued++;
      end
      if (rd_valid && rd_ready) begin
        if (sb_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL %s_extra_beat got data=%0d exp none", name, rd_data);
        end else begin
          exp = sb_q.pop_front();
          checks++;
          if (rd_data !== exp) begin
            errors++;
            $display("[TB] FAIL %s_data%0d got=%0d exp=%0d", name, got, rd_data, exp);
          end
        end
        if (got == 0 && rdy_mode == 0) begin
          checks++;
          if (cyc != 1) begin
            errors++;
            $display("[TB] FAIL %s_latency got=%0d exp=1 cycles after issue", name, cyc);
          end
        end
        got++;
      end
      checks++;
      if (issued - got > 2 || issued > nbeats) begin
        errors++;
        $display("[TB] FAIL %s_occupancy got outstanding=%0d issued=%0d exp outstanding<=2 issued<=%0d",
                 name, issued - got, issued, nbeats);
      end
      if (abort_after > 0 && got == abort_after) break;
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 300) begin
      errors++;
      $display("[TB] FAIL %s_timeout got beats=%0d exp=%0d", name, got, nbeats);
    end
    if (abort_after == 0) begin
      #1;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || issued != nbeats || sb_q.size() != 0) begin
        errors++;
        $display("[TB] FAIL %s_done got done=%b busy=%b issued=%0d left=%0d exp done=1 busy=0 issued=%0d left=0",
                 name, done, busy, issued, sb_q.size(), nbeats);
      end
    end
  endtask

  task automatic test_write_basic();
    do_write(5'd0, 5'd3, 32'd11, 1'b0, 1'b0, "wr_basic");
  endtask

  task automatic test_read_basic();
    do_read(5'd0, 5'd3, 0, 0, "rd_basic");
  endtask

  task automatic test_wrap();
    do_write(5'd30, 5'd3, 32'd100, 1'b0, 1'b0, "wr_wrap");
    do_read(5'd30, 5'd3, 0, 0, "rd_wrap");
  endtask

  task automatic test_backpressure();
    do_write(5'd8, 5'd7, 32'd7, 1'b0, 1'b0, "wr_bp");
    do_read(5'd8, 5'd7, 1, 0, "rd_bp");
  endtask

  task automatic test_reset_mid_read();
    do_read(5'd8, 5'd7, 0, 3, "rd_abort");
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rd_valid, busy, ram_ena} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL abort_state got rd_valid/busy/ena=%b exp=000", {rd_valid, busy, ram_ena});
    end
    rd_ready = 1'b0;
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    do_read(5'd0, 5'd3, 0, 0, "rd_after_abort");
  endtask

  task automatic test_req_during_write();
    do_write(5'd16, 5'd5, 32'd5, 1'b1, 1'b1, "wr_spam");
    do_read(5'd16, 5'd5, 1, 0, "rd_spam");
  endtask

  task automatic test_full_sweep();
    do_write(5'd5, 5'd31, 32'd3, 1'b0, 1'b0, "wr_full");
    do_read(5'd5, 5'd31, 0, 0, "rd_full");
  endtask

  initial begin
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    wr_valid  = 1'b0; wr_data = '0; rd_ready = 1'b0;
    test_reset();
    test_write_basic();
    test_read_basic();
    test_wrap();
    test_backpressure();
    test_reset_mid_read();
    test_req_during_write();
    test_full_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
